// File: rtl/alu_issue.sv
// Issue/write-back controller for a 32-bit ALU: decodes R-type words, reads operands from a
// 32x32 register file, presents one ALU operation, and writes the result back.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_rd1,
  output logic [31:0] alu_rd2,
  output logic [4:0]  alu_shift_amt,
  output logic        alu_valid,
  input  logic [31:0] alu_result,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {StIdle, StDecode, StExec} state_e;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpSll = 4'd4;
  localparam logic [3:0] OpSrl = 4'd5;
  localparam logic [3:0] OpSra = 4'd6;
  localparam logic [3:0] OpSgt = 4'd7;
  localparam logic [3:0] OpSlt = 4'd8;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic [31:0] instr_q;
  logic [3:0]  op_q, op_d;
  logic [31:0] rd1_q, rd1_d;
  logic [31:0] rd2_q, rd2_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [31:0] rf_q [32];

  logic        handshake;
  logic        wb_en;
  logic [5:0]  f_opcode;
  logic [4:0]  f_rs, f_rt, f_rd, f_shamt;
  logic [5:0]  f_funct;
  logic        dec_legal;
  logic        dec_shift;
  logic [3:0]  dec_op;

  assign handshake = instr_valid && ready_q;

  assign f_opcode = instr_q[31:26];
  assign f_rs     = instr_q[25:21];
  assign f_rt     = instr_q[20:16];
  assign f_rd     = instr_q[15:11];
  assign f_shamt  = instr_q[10:6];
  assign f_funct  = instr_q[5:0];

  always_comb begin
    dec_legal = 1'b0;
    dec_shift = 1'b0;
    dec_op    = OpAdd;
    if (f_opcode == 6'd0) begin
      case (f_funct)
        6'h20: begin dec_legal = 1'b1; dec_op = OpAdd; end
        6'h22: begin dec_legal = 1'b1; dec_op = OpSub; end
        6'h24: begin dec_legal = 1'b1; dec_op = OpAnd; end
        6'h25: begin dec_legal = 1'b1; dec_op = OpOr;  end
        6'h00: begin dec_legal = 1'b1; dec_op = OpSll; dec_shift = 1'b1; end
        6'h02: begin dec_legal = 1'b1; dec_op = OpSrl; dec_shift = 1'b1; end
        6'h03: begin dec_legal = 1'b1; dec_op = OpSra; dec_shift = 1'b1; end
        6'h2C: begin dec_legal = 1'b1; dec_op = OpSgt; end
        6'h2A: begin dec_legal = 1'b1; dec_op = OpSlt; end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    op_d      = op_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    shamt_d   = shamt_q;
    wb_en     = 1'b0;
    case (state_q)
      StIdle: begin
        if (handshake) state_d = StDecode;
      end
      StDecode: begin
        if (dec_legal) begin
          state_d = StExec;
          op_d    = dec_op;
          if (dec_shift) begin
            rd1_d   = rf_q[f_rt];
            rd2_d   = 32'd0;
            shamt_d = f_shamt;
          end else begin
            rd1_d   = rf_q[f_rs];
            rd2_d   = rf_q[f_rt];
            shamt_d = 5'd0;
          end
        end else begin
          state_d   = StIdle;
          illegal_d = 1'b1;
        end
      end
      StExec: begin
        state_d = StIdle;
        done_d  = 1'b1;
        wb_en   = (f_rd != 5'd0);
      end
      default: state_d = StIdle;
    endcase
    // Ready stays low for the first cycle after reset release because ready_q resets to 0.
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      instr_q   <= 32'd0;
      op_q      <= 4'd0;
      rd1_q     <= 32'd0;
      rd2_q     <= 32'd0;
      shamt_q   <= 5'd0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      op_q      <= op_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      shamt_q   <= shamt_d;
      if (handshake) instr_q <= instr;
    end
  end

  // R0 is never written; write-back takes priority over a debug write to the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wb_en && (f_rd == 5'(i))) begin
          rf_q[i] <= alu_result;
        end else if (dbg_we && (dbg_addr == 5'(i))) begin
          rf_q[i] <= dbg_wdata;
        end
      end
    end
  end

  assign instr_ready   = ready_q;
  assign done          = done_q;
  assign illegal       = illegal_q;
  assign alu_op        = op_q;
  assign alu_rd1       = rd1_q;
  assign alu_rd2       = rd2_q;
  assign alu_shift_amt = shamt_q;
  assign alu_valid     = (state_q == StExec);
  assign dbg_rdata     = rf_q[dbg_addr];

endmodule

// File: doc/alu_issue.md
# alu_issue

Sequential issue/write-back controller that drives the 32-bit ALU's operand interface (op, rd1, rd2, shift_amt) and consumes its result. It accepts R-type instruction words over a valid/ready handshake, decodes them, and reads operands from an internal 32×32 register file. It then presents one operation to the ALU and writes the ALU result back to the register file. It sits between the instruction source and the ALU, with a debug port for register preload and inspection.

## Interface
- No parameters; all widths fixed.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction word valid
- instr_ready  out  1  controller can accept an instruction
- instr  in  32  opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]
- alu_op  out  4  ALU operation code
- alu_rd1  out  32  ALU operand 1 (signed)
- alu_rd2  out  32  ALU operand 2 (signed)
- alu_shift_amt  out  5  ALU shift amount
- alu_valid  out  1  ALU inputs meaningful this cycle
- alu_result  in  32  ALU result (combinational from alu_* outputs)
- dbg_we  in  1  debug register write
- dbg_addr  in  5  debug read/write address
- dbg_wdata  in  32  debug write data
- dbg_rdata  out  32  combinational read of R[dbg_addr]
- done  out  1  one-cycle pulse: instruction completed
- illegal  out  1  one-cycle pulse: instruction rejected

## Operation
- States: IDLE, DECODE, EXEC.
  - IDLE → DECODE on instr_valid && instr_ready; instruction latched.
  - DECODE → EXEC if legal; DECODE → IDLE if illegal.
  - EXEC → IDLE always.
- instr_ready = 1 only in IDLE, and only after the first clock following reset release.
- Legal instructions require opcode == 0. funct maps to alu_op as follows:
  - 0x20 add → 0
  - 0x22 sub → 1
  - 0x24 and → 2
  - 0x25 or → 3
  - 0x00 sll → 4
  - 0x02 srl → 5
  - 0x03 sra → 6
  - 0x2C sgt → 7
  - 0x2A slt → 8
  - Any other funct, or any nonzero opcode, is illegal.
- Operand selection:
  - Shifts (sll, srl, sra): alu_rd1 = R[rt], alu_rd2 = 0, alu_shift_amt = shamt.
  - All other ops: alu_rd1 = R[rs], alu_rd2 = R[rt], alu_shift_amt = 0.
- Write-back: R[rd] ← alu_result at the end of EXEC.
  - A write to rd = 0 is discarded; R0 always reads 0.
  - Compare results are 0 or 1, zero-extended.
- Debug port:
  - dbg_we writes R[dbg_addr] on any cycle; writes to address 0 are ignored.
  - On a same-cycle, same-address collision with write-back, write-back wins.
- dbg_rdata is combinational. A written value is visible the cycle after the write edge.
- alu_op, alu_rd1, alu_rd2 and alu_shift_amt hold their last values outside EXEC. alu_valid = 1 only in EXEC.

## Timing
- Handshake at edge ending cycle N:
  - DECODE in N+1; operands read and registered at the end of N+1.
  - EXEC in N+2; alu_* stable, alu_valid = 1; write-back at the end of N+2.
  - done = 1 and instr_ready = 1 in N+3.
- Throughput: one instruction per 3 cycles. The next handshake can occur at the end of N+3, and its DECODE sees the N+2 write-back, so there is no hazard.
- Illegal instruction: illegal = 1 and instr_ready = 1 in N+2; no write, no alu_valid.
- Reset (asynchronous, may occur mid-operation):
  - Register file, state = IDLE, and all outputs cleared to 0 (instr_ready, done, illegal, alu_* all 0).
  - In-flight instruction aborted with no write-back.
- instr is ignored when instr_ready = 0.

## Test plan
- Reset: assert rst_n = 0 mid-run → all outputs 0, dbg_rdata for R5 = 0; release → instr_ready = 0 for one cycle, then 1.
- Add with timing:
  - Stimulus: dbg-load R1 = 5, R2 = 0xFFFFFFFD; issue add R3,R1,R2 at cycle N.
  - Response: in N+2, alu_op = 0, alu_rd1 = 5, alu_valid = 1; in N+3, done = 1 and R3 = 2.
- Shifts:
  - Stimulus: R2 = 0x80000000; issue sra R4,R2,4, then srl R5,R2,4, then sll R6,R2,1.
  - Response: R4 = 0xF8000000, R5 = 0x08000000, R6 = 0.
- Signed compares:
  - Stimulus: R1 = 0xFFFFFFFF, R2 = 1; issue slt R7,R1,R2, then sgt R8,R1,R2.
  - Response: R7 = 1, R8 = 0.
- Illegal:
  - Stimulus: instr with opcode 0x23, or funct 0x21.
  - Response: illegal pulse in N+2, instr_ready = 1 in N+2, no done, all registers unchanged.
- Hazards, R0 and abort:
  - Back-to-back: add R3,R1,R1 then add R4,R3,R3 with R1 = 7 → R4 = 28.
  - R0: add R0,R1,R1 → done pulses, R0 reads 0.
  - Abort: rst_n low during EXEC → no write-back, all registers 0.
